// File: rtl/bin_to_bcd_seq_if.sv
// rtl/bin_to_bcd_seq_if.sv - start/result handshake bundle for the sequential binary-to-BCD converter
interface bin_to_bcd_seq_if #(
  parameter int BIN_WIDTH = 16,
  parameter int DIGITS    = 5
);
  logic                    start;
  logic [BIN_WIDTH-1:0]    bin_in;
  logic                    busy;
  logic                    done;
  logic [4*DIGITS-1:0]     bcd_out;

  modport master (
    output start,
    output bin_in,
    input  busy,
    input  done,
    input  bcd_out
  );

  modport slave (
    input  start,
    input  bin_in,
    output busy,
    output done,
    output bcd_out
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - shift-and-add-3 binary-to-BCD converter, one bit per clock
// The result register only changes in DONE, so the display never sees partial digits.
module bin_to_bcd_seq #(
  parameter int BIN_WIDTH = 16,
  parameter int DIGITS    = 5
) (
  input  logic              clk,
  input  logic              reset,
  bin_to_bcd_seq_if.slave   bus
);
  localparam int SCR_W = 4*DIGITS + BIN_WIDTH;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                r_state;
  logic [SCR_W-1:0]      r_scr;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_busy;
  logic                  r_done;
  logic [4*DIGITS-1:0]   r_bcd_out;
  logic [SCR_W-1:0]      w_scr_adj;

  // Upper part of the scratch register holds the BCD accumulator, lower part the unshifted binary bits.
  always_comb begin
    w_scr_adj = r_scr;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_scr[BIN_WIDTH + 4*d +: 4] >= 4'd5) begin
        w_scr_adj[BIN_WIDTH + 4*d +: 4] = r_scr[BIN_WIDTH + 4*d +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_scr     <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_bcd_out <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_scr   <= {{(4*DIGITS){1'b0}}, bus.bin_in};
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_scr <= w_scr_adj << 1;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_CNT) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          // busy drops on the same edge done rises, which leaves the mandatory IDLE cycle.
          r_bcd_out <= r_scr[SCR_W-1 -: 4*DIGITS];
          r_done    <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.bcd_out = r_bcd_out;
endmodule
